// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronizes a bouncing raw level, accepts a new level
// after STABLE_CYCLES consistent samples, and emits one-cycle press/release strobes.
module debounce_pulse #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic ENABLE,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic BUSY
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   busy_q, busy_d;
    logic                   bsync;

    assign bsync = sync_q[SYNC_STAGES-1];

    // Synchronizer shifts whenever out of reset, independent of ENABLE.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], BTN};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q    <= '0;
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (ENABLE) begin
            case (state_q)
                IDLE_LOW: begin
                    if (bsync) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!bsync) begin
                        state_d = IDLE_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!bsync) begin
                        state_d = WAIT_LOW;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (bsync) begin
                        state_d = IDLE_HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                end
            endcase
        end

        // Registered from next state so BUSY tracks the state flops exactly.
        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    assign LEVEL   = level_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign BUSY    = busy_q;

endmodule
